zubri_link_rx: RTL and testbench
================================

# zubri_link_rx

Serial command receiver that sits directly upstream of the 27-bit-word / 8-bit-SRAM storage controller. It deserialises 38-bit command frames from the external link, checks length and parity, and sequences the controller's `write` / `read` / `parity` / `out_data` strobes. It holds each strobe long enough for the controller's clk/6 internal state machine to sample it, and it uses the controller's `adrWrite` pulse as the address-capture acknowledge.

## Interface
Parameters:
- `STROBE_CYC`, 12: clk cycles each data-phase strobe (`parity`, `out_data`) is held high; two controller cycles.
- `ACK_TIMEOUT`, 255: clk cycles to wait for `adr_ack` before aborting the frame.
- `CNT_W`, 8: width of the saturating error counters.

Ports:
- `clk` in 1: system clock, 50 MHz; single clock domain.
- `nrst` in 1: asynchronous, active-low reset.
- `ser_clk` in 1: link bit clock, asynchronous to `clk`, at most clk/8; data is valid on its rising edge.
- `ser_data` in 1: link data, MSB first.
- `ser_frame` in 1: high for the duration of a frame.
- `adr_ack` in 1: the controller's `adrWrite`; high for one controller cycle when the address is captured.
- `write` out 1: write request to the controller.
- `read` out 1: read request to the controller.
- `parity` out 1: write-data-valid strobe to the controller.
- `out_data` out 1: read-result-latch strobe to the controller.
- `out_A` out 9: word address.
- `out_D` out 27: write data.
- `busy` out 1: high from frame acceptance until the sequence ends (DONE or abort).
- `frame_err_cnt` out CNT_W: saturating count of length, parity and overrun errors.
- `timeout_cnt` out CNT_W: saturating count of acknowledge timeouts.

## Operation
- Frame format, 38 bits, MSB first:
  - bit 37: op (1 = write, 0 = read)
  - bits 36:28: address
  - bits 27:1: data (ignored for reads)
  - bit 0: odd-parity bit over bits 37:1
- Input conditioning: `ser_clk`, `ser_data` and `ser_frame` each pass through a 2-flop synchroniser. Bit capture happens on the detected `ser_clk` rising edge while the synchronised `ser_frame` is 1.
- State machine:
  - IDLE: the rising edge of `ser_frame` clears the shift register and the bit counter, then goes to SHIFT.
  - SHIFT: shift in one bit per `ser_clk` edge. The counter saturates at 39. On the falling edge of `ser_frame`, go to CHECK.
  - CHECK:
    - If the count is not 38, increment `frame_err_cnt` and go to IDLE.
    - If the parity check fails, increment `frame_err_cnt` and go to IDLE.
    - Otherwise latch `out_A`/`out_D`, then go to REQ.
  - REQ: hold `write` (op=1) or `read` (op=0) high.
    - On the rising edge of `adr_ack`, drop the request and go to DATA (write) or FETCH (read).
    - After ACK_TIMEOUT cycles without an edge, drop the request, increment `timeout_cnt` and go to IDLE.
  - DATA: `parity` high for STROBE_CYC cycles, then go to DONE.
  - FETCH: wait STROBE_CYC cycles (read latency), then `out_data` high for STROBE_CYC cycles, then go to DONE.
  - DONE: wait STROBE_CYC cycles so the controller can return to its wait state, then go to IDLE.
- Overrun: a `ser_frame` rising edge in any state other than IDLE and SHIFT increments `frame_err_cnt`. That frame is ignored, and the current sequence is unaffected.
- `write` and `read` are never high simultaneously. `parity` and `out_data` are never high simultaneously.
- `out_A` and `out_D` are stable from CHECK exit until the next CHECK success.
- The counters saturate at 2^CNT_W−1 and are cleared only by reset.

## Timing
- Reset values: every output is 0, and the state is IDLE. Reset asserted mid-sequence drops all strobes asynchronously.
- `busy` rises the cycle after CHECK succeeds. It falls when the FSM enters IDLE.
- From the `ser_frame` falling edge (synchronised) to the request going high is 2 clk cycles.
- The request is high for at least 1 cycle. It goes low 1 cycle after the sampled `adr_ack` rising edge.
- Write sequence after ack: 2·STROBE_CYC cycles; the default is 24.
- Read sequence after ack: 3·STROBE_CYC cycles; the default is 36.
- A `ser_frame` edge and a `ser_clk` edge in the same cycle: the `ser_frame` edge takes precedence, and that bit is not captured.

## Configuration
- `LINK_RX_PARITY_EN` defined: odd parity is checked in CHECK. A mismatch drops the frame and increments `frame_err_cnt`.
- `LINK_RX_PARITY_EN` undefined: bit 0 is ignored, and the parity check logic is not generated. Only the length check applies.

## Test plan
- Write frame, op=1, addr=0x0A5, data=0x5A5A5A5, correct parity; `adr_ack` pulses 3 cycles after `write` rises.
  - Required: `write` drops 1 cycle after the ack, then `parity` is high for 12 cycles with `out_A`=0x0A5 and `out_D`=0x5A5A5A5.
  - Required: `busy` is low 24 cycles after the ack.
- Read frame, addr=0x1FF, with ack.
  - Required: `read` → ack → 12 idle cycles → `out_data` high for 12 cycles; `write` and `parity` stay 0.
- Bad parity with `LINK_RX_PARITY_EN`: no strobe, and `frame_err_cnt`=1.
  - Same frame built without the macro: the write is issued.
- 37-bit frame: no strobe, and `frame_err_cnt` increments.
  - 39-bit frame: same response.
- No ack:
  - Required: `write` is high for exactly 255 cycles, then `timeout_cnt`=1, `busy`=0.
  - Required: the next valid frame completes normally.
- Second frame during DATA: counted as overrun, and the first write completes intact.
  - Assert `nrst` during FETCH: all outputs go to 0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/zubri_link_rx_if.sv
// zubri_link_rx_if: command bus between the link receiver and the
// 27-bit-word storage controller. The receiver drives the request and
// data-phase strobes plus the latched address/data; the controller
// returns its address-capture pulse (adrWrite) as adr_ack.
interface zubri_link_rx_if;
  logic        write;
  logic        read;
  logic        parity;
  logic        out_data;
  logic [8:0]  out_A;
  logic [26:0] out_D;
  logic        adr_ack;

  modport master (
    output write, read, parity, out_data, out_A, out_D,
    input  adr_ack
  );

  modport slave (
    input  write, read, parity, out_data, out_A, out_D,
    output adr_ack
  );
endinterface

// File: rtl/zubri_link_rx.sv
// zubri_link_rx: serial command receiver in front of the storage controller.
// Deserialises 38-bit frames (op, 9-bit address, 27-bit data, odd parity),
// checks them and sequences write/read, parity and out_data strobes, holding
// each long enough for the controller's clk/6 state machine.
// Optional feature macro: LINK_RX_PARITY_EN -- when defined, odd parity over
// the whole frame is checked; when undefined only the length is checked.
module zubri_link_rx #(
  parameter int STROBE_CYC  = 12,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               ser_clk,
  input  logic               ser_data,
  input  logic               ser_frame,
  zubri_link_rx_if.master    bus,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_err_cnt,
  output logic [CNT_W-1:0]   timeout_cnt
);

  localparam logic [5:0] FRAME_LEN = 6'd38;
  localparam logic [5:0] BCNT_MAX  = 6'd39;

  // One shared timer covers the ack wait and all data-phase windows.
  localparam int TMR_MAX = (ACK_TIMEOUT > 2 * STROBE_CYC) ? ACK_TIMEOUT : 2 * STROBE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ONE        = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_ACK_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_STB_LAST   = TMR_W'(STROBE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_FETCH_LAST = TMR_W'(2 * STROBE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_REQ   = 3'd3,
    ST_DATA  = 3'd4,
    ST_FETCH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Saturating +1 for the error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef LINK_RX_PARITY_EN
  // Odd parity: the XOR of all 38 frame bits, parity bit included, is 1.
  function automatic logic odd_parity_ok(input logic [37:0] f);
    return ^f;
  endfunction
`endif

  // Synchroniser and edge-detect registers
  logic ser_clk_meta_r, ser_clk_sync_r, ser_clk_prev_r;
  logic ser_data_meta_r, ser_data_sync_r;
  logic frame_meta_r, frame_sync_r, frame_prev_r;
  logic adr_ack_prev_r;

  // FSM and datapath registers
  state_t            state_r;
  logic [37:0]       shift_r;
  logic [5:0]        bit_cnt_r;
  logic [TMR_W-1:0]  timer_r;
  logic              op_r;
  logic              write_r, read_r, parity_r, out_data_r, busy_r;
  logic [8:0]        addr_r;
  logic [26:0]       data_r;
  logic [CNT_W-1:0]  frame_err_r, timeout_r;

  // Next-state values
  state_t            state_nxt_s;
  logic [37:0]       shift_nxt_s;
  logic [5:0]        bit_cnt_nxt_s;
  logic [TMR_W-1:0]  timer_nxt_s;
  logic              op_nxt_s;
  logic              write_nxt_s, read_nxt_s, parity_nxt_s, out_data_nxt_s, busy_nxt_s;
  logic [8:0]        addr_nxt_s;
  logic [26:0]       data_nxt_s;
  logic [CNT_W-1:0]  frame_err_nxt_s, timeout_nxt_s;

  logic sclk_rise_s, frame_rise_s, frame_fall_s, ack_rise_s;
  logic frame_ok_s;

  assign sclk_rise_s  = ser_clk_sync_r & ~ser_clk_prev_r;
  assign frame_rise_s = frame_sync_r & ~frame_prev_r;
  assign frame_fall_s = ~frame_sync_r & frame_prev_r;
  assign ack_rise_s   = bus.adr_ack & ~adr_ack_prev_r;

`ifdef LINK_RX_PARITY_EN
  assign frame_ok_s = (bit_cnt_r == FRAME_LEN) && odd_parity_ok(shift_r);
`else
  assign frame_ok_s = (bit_cnt_r == FRAME_LEN);
`endif

  // Two-flop synchronisers for the link inputs plus previous-value flops for edge detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ser_clk_meta_r  <= 1'b0;
      ser_clk_sync_r  <= 1'b0;
      ser_clk_prev_r  <= 1'b0;
      ser_data_meta_r <= 1'b0;
      ser_data_sync_r <= 1'b0;
      frame_meta_r    <= 1'b0;
      frame_sync_r    <= 1'b0;
      frame_prev_r    <= 1'b0;
      adr_ack_prev_r  <= 1'b0;
    end else begin
      ser_clk_meta_r  <= ser_clk;
      ser_clk_sync_r  <= ser_clk_meta_r;
      ser_clk_prev_r  <= ser_clk_sync_r;
      ser_data_meta_r <= ser_data;
      ser_data_sync_r <= ser_data_meta_r;
      frame_meta_r    <= ser_frame;
      frame_sync_r    <= frame_meta_r;
      frame_prev_r    <= frame_sync_r;
      adr_ack_prev_r  <= bus.adr_ack;
    end
  end

  // Next-state, strobe and counter logic for the frame/command sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    timer_nxt_s     = timer_r;
    op_nxt_s        = op_r;
    write_nxt_s     = write_r;
    read_nxt_s      = read_r;
    parity_nxt_s    = parity_r;
    out_data_nxt_s  = out_data_r;
    addr_nxt_s      = addr_r;
    data_nxt_s      = data_r;
    frame_err_nxt_s = frame_err_r;
    timeout_nxt_s   = timeout_r;

    case (state_r)
      ST_IDLE: begin
        if (frame_rise_s) begin
          shift_nxt_s   = '0;
          bit_cnt_nxt_s = '0;
          state_nxt_s   = ST_SHIFT;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // A frame edge wins over a bit edge in the same cycle.
        if (frame_fall_s) begin
          state_nxt_s = ST_CHECK;
        end else if (sclk_rise_s && frame_sync_r) begin
          shift_nxt_s = {shift_r[36:0], ser_data_sync_r};
          if (bit_cnt_r != BCNT_MAX) begin
            bit_cnt_nxt_s = bit_cnt_r + 6'd1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end

      ST_CHECK: begin
        if (!frame_ok_s) begin
          frame_err_nxt_s = sat_inc(frame_err_r);
          state_nxt_s     = ST_IDLE;
        end else begin
          op_nxt_s    = shift_r[37];
          addr_nxt_s  = shift_r[36:28];
          data_nxt_s  = shift_r[27:1];
          write_nxt_s = shift_r[37];
          read_nxt_s  = ~shift_r[37];
          timer_nxt_s = '0;
          state_nxt_s = ST_REQ;
        end
      end

      ST_REQ: begin
        // An ack landing on the last timeout cycle still counts as an ack.
        if (ack_rise_s) begin
          write_nxt_s = 1'b0;
          read_nxt_s  = 1'b0;
          timer_nxt_s = '0;
          if (op_r) begin
            parity_nxt_s = 1'b1;
            state_nxt_s  = ST_DATA;
          end else begin
            state_nxt_s  = ST_FETCH;
          end
        end else if (timer_r == TMR_ACK_LAST) begin
          write_nxt_s   = 1'b0;
          read_nxt_s    = 1'b0;
          timer_nxt_s   = '0;
          timeout_nxt_s = sat_inc(timeout_r);
          state_nxt_s   = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end

      ST_DATA: begin
        if (timer_r == TMR_STB_LAST) begin
          parity_nxt_s = 1'b0;
          timer_nxt_s  = '0;
          state_nxt_s  = ST_DONE;
        end else begin
          timer_nxt_s  = timer_r + TMR_ONE;
        end
      end

      ST_FETCH: begin
        // First window models the read latency, second holds out_data.
        if (timer_r == TMR_FETCH_LAST) begin
          out_data_nxt_s = 1'b0;
          timer_nxt_s    = '0;
          state_nxt_s    = ST_DONE;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
          if (timer_r == TMR_STB_LAST) begin
            out_data_nxt_s = 1'b1;
          end else begin
            out_data_nxt_s = out_data_r;
          end
        end
      end

      ST_DONE: begin
        if (timer_r == TMR_STB_LAST) begin
          timer_nxt_s = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TMR_ONE;
        end
      end

      default: begin
        write_nxt_s    = 1'b0;
        read_nxt_s     = 1'b0;
        parity_nxt_s   = 1'b0;
        out_data_nxt_s = 1'b0;
        timer_nxt_s    = '0;
        state_nxt_s    = ST_IDLE;
      end
    endcase

    // A new frame while a command is in flight is dropped and counted.
    if (frame_rise_s && (state_r != ST_IDLE) && (state_r != ST_SHIFT)) begin
      frame_err_nxt_s = sat_inc(frame_err_nxt_s);
    end else begin
      frame_err_nxt_s = frame_err_nxt_s;
    end

    busy_nxt_s = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DATA) ||
                 (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DONE);
  end

  // State, datapath and registered outputs; reset clears strobes asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      timer_r     <= '0;
      op_r        <= 1'b0;
      write_r     <= 1'b0;
      read_r      <= 1'b0;
      parity_r    <= 1'b0;
      out_data_r  <= 1'b0;
      busy_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      frame_err_r <= '0;
      timeout_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      timer_r     <= timer_nxt_s;
      op_r        <= op_nxt_s;
      write_r     <= write_nxt_s;
      read_r      <= read_nxt_s;
      parity_r    <= parity_nxt_s;
      out_data_r  <= out_data_nxt_s;
      busy_r      <= busy_nxt_s;
      addr_r      <= addr_nxt_s;
      data_r      <= data_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  assign bus.write      = write_r;
  assign bus.read       = read_r;
  assign bus.parity     = parity_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_A      = addr_r;
  assign bus.out_D      = data_r;
  assign busy           = busy_r;
  assign frame_err_cnt  = frame_err_r;
  assign timeout_cnt    = timeout_r;

endmodule

// File: tb/tb_zubri_link_rx.sv
// tb_zubri_link_rx: table-driven and randomized bench for zubri_link_rx.
// Frames are bit-banged on the link at clk/8; the controller side answers
// with a 6-cycle adr_ack pulse. Expected strobe timelines come from the
// frame rules (length, odd parity, op) and the strobe-window lengths.
`timescale 1ns/1ps
module tb_zubri_link_rx;
  localparam int S  = 12;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_frame;
  logic       busy;
  logic [7:0] frame_err_cnt;
  logic [7:0] timeout_cnt;

  zubri_link_rx_if bus();

  zubri_link_rx #(.STROBE_CYC(S), .ACK_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_frame(ser_frame), .bus(bus), .busy(busy),
    .frame_err_cnt(frame_err_cnt), .timeout_cnt(timeout_cnt)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int exp_to = 0;
  logic [8:0]  last_addr = 9'h0;
  logic [26:0] last_data = 27'h0;

  typedef struct {
    logic        op;
    logic [8:0]  addr;
    logic [26:0] data;
    int          len;
    logic        bad;
    int          ack_dly;
    int          ovr;
    int          exp_kind;   // 0 dropped, 1 write, 2 read
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] obs();
    return {bus.write, bus.read, bus.parity, bus.out_data, busy, bus.out_A, bus.out_D};
  endfunction

  function automatic logic [40:0] ev(input logic w, input logic r, input logic p,
                                     input logic o, input logic b,
                                     input logic [8:0] a, input logic [26:0] d);
    return {w, r, p, o, b, a, d};
  endfunction

  function automatic logic [37:0] make_frame(input logic op, input logic [8:0] addr,
                                             input logic [26:0] data, input logic bad);
    logic [36:0] payload;
    payload = {op, addr, data};
    return {payload, (~(^payload)) ^ bad};
  endfunction

  // Reference: a frame is accepted when it has 38 bits and (if checked) odd total parity.
  function automatic int model_kind(input logic [37:0] f, input int len);
    logic ok;
    ok = (len == 38);
`ifdef LINK_RX_PARITY_EN
    if ((f[0] + f[1] + f[2] + f[3] + f[4] + f[5] + f[6] + f[7] + f[8] + f[9] +
         f[10] + f[11] + f[12] + f[13] + f[14] + f[15] + f[16] + f[17] + f[18] + f[19] +
         f[20] + f[21] + f[22] + f[23] + f[24] + f[25] + f[26] + f[27] + f[28] + f[29] +
         f[30] + f[31] + f[32] + f[33] + f[34] + f[35] + f[36] + f[37]) % 2 == 0)
      ok = 1'b0;
`endif
    if (!ok) return 0;
    return f[37] ? 1 : 2;
  endfunction

  task automatic send_frame(input logic [37:0] f, input int len);
    @(negedge clk);
    ser_frame = 1'b1;
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < len; i++) begin
      ser_data = (i < 38) ? f[37-i] : 1'b1;
      repeat (4) @(negedge clk);
      ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      ser_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ser_frame = 1'b0;
  endtask

  task automatic run_txn(input logic op, input logic [8:0] addr, input logic [26:0] data,
                         input int len, input logic bad, input int ack_dly, input int ovr,
                         input int kind, input string tag);
    logic [37:0] f;
    int seq;
    logic w, r;
    f = make_frame(op, addr, data, bad);
    send_frame(f, len);
    if (kind == 0) begin
      if (exp_err < 255) exp_err++;
      for (int j = 1; j <= 12; j++) begin
        @(negedge clk);
        check({tag, "_dropped"}, obs(), ev(0, 0, 0, 0, 0, last_addr, last_data));
      end
    end else begin
      w = (kind == 1);
      r = (kind == 2);
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        check({tag, "_req_latency"}, obs(), ev(0, 0, 0, 0, 0, last_addr, last_data));
      end
      @(negedge clk);
      last_addr = addr;
      last_data = data;
      check({tag, "_req_rise"}, obs(), ev(w, r, 0, 0, 1, addr, data));
      if (ack_dly < 0) begin
        for (int j = 1; j <= TO; j++) begin
          @(negedge clk);
          if (j < TO) check({tag, "_req_hold"}, obs(), ev(w, r, 0, 0, 1, addr, data));
          else        check({tag, "_timeout_drop"}, obs(), ev(0, 0, 0, 0, 0, addr, data));
        end
        if (exp_to < 255) exp_to++;
      end else begin
        for (int j = 1; j <= ack_dly; j++) begin
          @(negedge clk);
          check({tag, "_req_wait"}, obs(), ev(w, r, 0, 0, 1, addr, data));
        end
        bus.adr_ack = 1'b1;
        seq = w ? 2 * S : 3 * S;
        for (int j = 1; j <= seq + 1; j++) begin
          @(negedge clk);
          if (j == 6) bus.adr_ack = 1'b0;
          if (j == ovr) ser_frame = 1'b1;
          check({tag, "_seq"}, obs(),
                ev(0, 0, w && (j <= S), r && (j > S) && (j <= 2 * S), j <= seq, addr, data));
        end
        if (ovr > 0) begin
          if (exp_err < 255) exp_err++;
          ser_frame = 1'b0;
          for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            check({tag, "_after_overrun"}, obs(), ev(0, 0, 0, 0, 0, addr, data));
          end
        end
      end
    end
    check({tag, "_frame_err_cnt"}, frame_err_cnt, exp_err);
    check({tag, "_timeout_cnt"}, timeout_cnt, exp_to);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [37:0] f;
    logic        op;
    logic [8:0]  addr;
    logic [26:0] data;
    int          len, ack, pick;
    logic        bad;

    tbl[0] = '{1'b1, 9'h0A5, 27'h5A5A5A5, 38, 1'b0, 3, 0, 1};
    tbl[1] = '{1'b0, 9'h1FF, 27'h1234567, 38, 1'b0, 3, 0, 2};
`ifdef LINK_RX_PARITY_EN
    tbl[2] = '{1'b1, 9'h033, 27'h7FFFFFF, 38, 1'b1, 3, 0, 0};
`else
    tbl[2] = '{1'b1, 9'h033, 27'h7FFFFFF, 38, 1'b1, 3, 0, 1};
`endif
    tbl[3] = '{1'b1, 9'h100, 27'h0000001, 37, 1'b0, 3, 0, 0};
    tbl[4] = '{1'b0, 9'h0FF, 27'h2AAAAAA, 39, 1'b0, 3, 0, 0};
    tbl[5] = '{1'b1, 9'h077, 27'h1111111, 38, 1'b0, -1, 0, 1};
    tbl[6] = '{1'b1, 9'h0C3, 27'h3C3C3C3, 38, 1'b0, 0, 0, 1};
    tbl[7] = '{1'b1, 9'h011, 27'h0ABCDEF, 38, 1'b0, 4, 2, 1};

    nrst = 1'b0;
    ser_clk = 1'b0;
    ser_data = 1'b0;
    ser_frame = 1'b0;
    bus.adr_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", obs(), 41'h0);
    check("reset_counters", {frame_err_cnt, timeout_cnt}, 16'h0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].len, tbl[i].bad,
              tbl[i].ack_dly, tbl[i].ovr, tbl[i].exp_kind, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      op   = 1'($urandom_range(0, 1));
      addr = 9'($urandom);
      data = 27'($urandom);
      pick = $urandom_range(0, 5);
      len  = (pick == 0) ? 37 : ((pick == 1) ? 39 : 38);
      bad  = ($urandom_range(0, 3) == 0);
      ack  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 10);
      f    = make_frame(op, addr, data, bad);
      run_txn(op, addr, data, len, bad, ack, 0, model_kind(f, len), $sformatf("rnd%0d", i));
    end

    // Reset while out_data is high in the read sequence.
    f = make_frame(1'b0, 9'h155, 27'h0F0F0F0, 1'b0);
    send_frame(f, 38);
    repeat (4) @(negedge clk);
    check("rst_read_req", obs(), ev(0, 1, 0, 0, 1, 9'h155, 27'h0F0F0F0));
    bus.adr_ack = 1'b1;
    repeat (6) @(negedge clk);
    bus.adr_ack = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_out_data_high", obs(), ev(0, 0, 0, 1, 1, 9'h155, 27'h0F0F0F0));
    #3 nrst = 1'b0;
    #1;
    check("rst_async_outputs", obs(), 41'h0);
    check("rst_async_counters", {frame_err_cnt, timeout_cnt}, 16'h0);
    @(negedge clk);
    nrst = 1'b1;
    exp_err = 0;
    exp_to = 0;
    last_addr = 9'h0;
    last_data = 27'h0;
    repeat (4) @(negedge clk);
    check("rst_idle_after", obs(), 41'h0);
    run_txn(1'b1, 9'h0AA, 27'h5555555, 38, 1'b0, 2, 0, 1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
